// File: rtl/e2prom_pkg.sv
// e2prom_pkg
// Shared definitions for the EEPROM write/read-back self-test sequencer:
//   state_t      - sequencer state encoding
//   RD / WR      - values driven on i2c_rh_wl
//   pattern_byte - test pattern generator, data = offset ^ seed
package e2prom_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_GAP  = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_CHECK   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // The byte written to (and later expected from) a given offset of the range.
  function automatic logic [7:0] pattern_byte(input logic [7:0] offset,
                                              input logic [7:0] seed);
    return offset ^ seed;
  endfunction

endpackage

// File: rtl/e2prom_rw_seq_wait_timer.sv
// wait_timer
// Load/count-down counter used to hold off after each EEPROM write while the
// device finishes its internal program cycle.
//   clk   in  - rising-edge clock
//   rst_n in  - asynchronous active-low reset (count cleared to 0)
//   load  in  - load 'value' into the counter this cycle
//   value in  - reload value
//   zero  out - counter currently holds 0
module wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Count down towards zero and park there; a load always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/e2prom_rw_seq.sv
// e2prom_rw_seq
// Drives the i2c_dri command interface through an EEPROM self-test: write a
// pattern over BYTE_NUM bytes from ADDR_START, wait out the write cycle after
// each byte, read everything back and compare. Reports pass/fail and the
// first failing address.
//   clk, rst_n          - dri_clk from i2c_dri, async active-low reset
//   start               - begin a test (only honoured when not busy)
//   i2c_done/ack/data_r - completion pulse, NACK flag, read data from driver
//   i2c_exec/rh_wl/addr/data_w - registered command to the driver
//   bit_ctrl            - 16-bit (1) or 8-bit (0) word address select
//   busy/pass/fail/fail_addr - test status
module e2prom_rw_seq
  import e2prom_pkg::*;
#(
  parameter bit          ADDR16      = 1'b1,
  parameter logic [15:0] ADDR_START  = 16'h0000,
  parameter int          BYTE_NUM    = 256,
  parameter int          WR_WAIT_MAX = 5000,
  parameter logic [7:0]  SEED        = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  output logic        bit_ctrl,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic [15:0] fail_addr
);

  localparam int              TW       = $clog2(WR_WAIT_MAX + 1);
  localparam logic [TW-1:0]   GAP_LOAD = TW'(WR_WAIT_MAX - 1);
  // idx is one bit wider than an address so BYTE_NUM = 65536 still ends.
  localparam logic [16:0]     LAST_IDX = 17'(BYTE_NUM - 1);

  state_t      r_state, w_state_nxt;
  logic [16:0] r_idx, w_idx_nxt;
  logic        r_exec, w_exec_nxt;
  logic        r_rh_wl, w_rh_wl_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [7:0]  r_data_w, w_data_w_nxt;
  logic [7:0]  r_rdata, w_rdata_nxt;
  logic        r_pass, w_pass_nxt;
  logic        r_fail, w_fail_nxt;
  logic [15:0] r_fail_addr, w_fail_addr_nxt;
  logic        w_gap_load;
  logic        w_gap_zero;

  wait_timer #(
    .WIDTH (TW)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_gap_load),
    .value (GAP_LOAD),
    .zero  (w_gap_zero)
  );

  // State and datapath registers; everything clears to idle on reset so the
  // command strobe drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_exec      <= 1'b0;
      r_rh_wl     <= 1'b0;
      r_addr      <= '0;
      r_data_w    <= '0;
      r_rdata     <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_exec      <= w_exec_nxt;
      r_rh_wl     <= w_rh_wl_nxt;
      r_addr      <= w_addr_nxt;
      r_data_w    <= w_data_w_nxt;
      r_rdata     <= w_rdata_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
      r_fail_addr <= w_fail_addr_nxt;
    end
  end

  // Next-state and datapath decisions. The command registers are loaded on
  // the edge that enters a REQ state, so they are already valid during the
  // one-cycle exec strobe and stay put until the next request.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_exec_nxt      = 1'b0;
    w_rh_wl_nxt     = r_rh_wl;
    w_addr_nxt      = r_addr;
    w_data_w_nxt    = r_data_w;
    w_rdata_nxt     = r_rdata;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;
    w_fail_addr_nxt = r_fail_addr;
    w_gap_load      = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_pass_nxt      = 1'b0;
          w_fail_nxt      = 1'b0;
          w_fail_addr_nxt = '0;
          w_idx_nxt       = '0;
          w_state_nxt     = S_WR_REQ;
        end
      end
      S_WR_REQ: w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            w_fail_nxt      = 1'b1;
            w_fail_addr_nxt = r_addr;
            w_state_nxt     = S_DONE;
          end else begin
            w_gap_load  = 1'b1;
            w_state_nxt = S_WR_GAP;
          end
        end
      end
      S_WR_GAP: begin
        if (w_gap_zero) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_RD_REQ;
          end else begin
            w_idx_nxt   = r_idx + 17'd1;
            w_state_nxt = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            w_fail_nxt      = 1'b1;
            w_fail_addr_nxt = r_addr;
            w_state_nxt     = S_DONE;
          end else begin
            w_rdata_nxt = i2c_data_r;
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (r_rdata != pattern_byte(r_idx[7:0], SEED)) begin
          w_fail_nxt      = 1'b1;
          w_fail_addr_nxt = r_addr;
          w_state_nxt     = S_DONE;
        end else if (r_idx == LAST_IDX) begin
          w_pass_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 17'd1;
          w_state_nxt = S_RD_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt == S_WR_REQ) begin
      w_exec_nxt   = 1'b1;
      w_rh_wl_nxt  = WR;
      w_addr_nxt   = ADDR_START + w_idx_nxt[15:0];
      w_data_w_nxt = pattern_byte(w_idx_nxt[7:0], SEED);
    end else if (w_state_nxt == S_RD_REQ) begin
      w_exec_nxt  = 1'b1;
      w_rh_wl_nxt = RD;
      w_addr_nxt  = ADDR_START + w_idx_nxt[15:0];
    end
  end

  assign i2c_exec   = r_exec;
  assign i2c_rh_wl  = r_rh_wl;
  assign i2c_addr   = r_addr;
  assign i2c_data_w = r_data_w;
  assign bit_ctrl   = ADDR16;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_addr  = r_fail_addr;

endmodule

// File: tb/tb_e2prom_rw_seq.sv
// tb_e2prom_rw_seq
// Self-checking bench for e2prom_rw_seq. A behavioural i2c_dri + EEPROM
// responder answers each command 3 cycles after the exec strobe, and can
// NACK one address or corrupt the read-back of one address.
module tb_e2prom_rw_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [7:0]  i2c_data_r = 8'h00;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic        bit_ctrl;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [15:0] fail_addr;

  int checks = 0;
  int errors = 0;

  e2prom_rw_seq #(
    .ADDR16      (1'b1),
    .ADDR_START  (16'h0010),
    .BYTE_NUM    (4),
    .WR_WAIT_MAX (10),
    .SEED        (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .i2c_done   (i2c_done),
    .i2c_ack    (i2c_ack),
    .i2c_data_r (i2c_data_r),
    .i2c_exec   (i2c_exec),
    .i2c_rh_wl  (i2c_rh_wl),
    .i2c_addr   (i2c_addr),
    .i2c_data_w (i2c_data_w),
    .bit_ctrl   (bit_ctrl),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .fail_addr  (fail_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder configuration, written only by the main test process.
  logic        nackEn = 1'b0;
  logic [15:0] nackAddr = 16'h0000;
  logic        corruptEn = 1'b0;
  logic [15:0] corruptAddr = 16'h0000;

  // Transaction log, written only by the responder.
  logic [15:0] logAddr [0:127];
  logic        logRw   [0:127];
  logic [7:0]  logData [0:127];
  int          execCyc [0:127];
  int          doneCyc [0:127];
  int          execCount = 0;
  logic [7:0]  mem [0:255];
  int          pendCnt = 0;
  int          pendIdx = 0;

  // Behavioural driver + EEPROM, acting on the falling edge.
  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    if (!rst_n) begin
      pendCnt = 0;
    end else begin
      if (pendCnt > 0) begin
        pendCnt = pendCnt - 1;
        if (pendCnt == 0) begin
          i2c_done = 1'b1;
          doneCyc[pendIdx] = cyc;
          if (nackEn && logAddr[pendIdx] == nackAddr) begin
            i2c_ack = 1'b1;
          end else if (logRw[pendIdx]) begin
            if (corruptEn && logAddr[pendIdx] == corruptAddr)
              i2c_data_r = 8'h00;
            else
              i2c_data_r = mem[logAddr[pendIdx][7:0]];
          end else begin
            mem[logAddr[pendIdx][7:0]] = logData[pendIdx];
          end
        end
      end
      if (i2c_exec) begin
        logAddr[execCount] = i2c_addr;
        logRw[execCount]   = i2c_rh_wl;
        logData[execCount] = i2c_data_w;
        execCyc[execCount] = cyc;
        pendIdx   = execCount;
        execCount = execCount + 1;
        pendCnt   = 3;
      end
    end
  end

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    int          gap;
  } txn_t;

  txn_t tab [0:7];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle start pulse, launched on the next falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n;
    n = 0;
    while (busy && n < maxCyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic waitExecs(input string name, input int base, input int n,
                           input int maxCyc);
    int k;
    k = 0;
    while ((execCount - base) < n && k < maxCyc) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput({name, "_exec_timeout"}, ((execCount - base) >= n), 1'b1);
  endtask

  task automatic checkTxns(input string name, input int base);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_t%0d_addr", name, i), logAddr[base+i], tab[i].addr);
      checkOutput($sformatf("%s_t%0d_rw", name, i), logRw[base+i], tab[i].rw);
      if (!tab[i].rw)
        checkOutput($sformatf("%s_t%0d_data", name, i), logData[base+i], tab[i].data);
      if (i < 7)
        checkOutput($sformatf("%s_t%0d_gap", name, i),
                    execCyc[base+i+1] - doneCyc[base+i], tab[i].gap);
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_exec"}, i2c_exec, 1'b0);
    checkOutput({name, "_busy"}, busy, 1'b0);
    checkOutput({name, "_pass"}, pass, 1'b0);
    checkOutput({name, "_fail"}, fail, 1'b0);
    checkOutput({name, "_fail_addr"}, fail_addr, 16'h0000);
    checkOutput({name, "_addr"}, i2c_addr, 16'h0000);
    checkOutput({name, "_data_w"}, i2c_data_w, 8'h00);
    checkOutput({name, "_rh_wl"}, i2c_rh_wl, 1'b0);
    checkOutput({name, "_bit_ctrl"}, bit_ctrl, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;

    // Expected sequence: 4 writes of offset^A5, then 4 reads; write done to
    // next exec is WR_WAIT_MAX+1 = 11 cycles, read done to next exec is 2.
    tab[0] = '{1'b0, 16'h0010, 8'hA5, 11};
    tab[1] = '{1'b0, 16'h0011, 8'hA4, 11};
    tab[2] = '{1'b0, 16'h0012, 8'hA7, 11};
    tab[3] = '{1'b0, 16'h0013, 8'hA6, 11};
    tab[4] = '{1'b1, 16'h0010, 8'h00, 2};
    tab[5] = '{1'b1, 16'h0011, 8'h00, 2};
    tab[6] = '{1'b1, 16'h0012, 8'h00, 2};
    tab[7] = '{1'b1, 16'h0013, 8'h00, 0};

    repeat (3) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_n = 1'b1;

    // Nominal run.
    base = execCount;
    applyStimulus();
    checkOutput("nom_first_exec", i2c_exec, 1'b1);
    checkOutput("nom_first_addr", i2c_addr, 16'h0010);
    checkOutput("nom_first_data", i2c_data_w, 8'hA5);
    checkOutput("nom_busy", busy, 1'b1);
    waitIdle("nom", 1000);
    checkOutput("nom_pass", pass, 1'b1);
    checkOutput("nom_fail", fail, 1'b0);
    checkOutput("nom_exec_count", execCount - base, 8);
    checkTxns("nom", base);

    // Read mismatch at 0012: stops before reading 0013.
    corruptEn = 1'b1;
    corruptAddr = 16'h0012;
    base = execCount;
    applyStimulus();
    waitIdle("mis", 1000);
    checkOutput("mis_fail", fail, 1'b1);
    checkOutput("mis_pass", pass, 1'b0);
    checkOutput("mis_fail_addr", fail_addr, 16'h0012);
    checkOutput("mis_exec_count", execCount - base, 7);
    checkOutput("mis_last_addr", logAddr[execCount-1], 16'h0012);

    // Re-run from DONE after a fail: flags clear one cycle after start.
    corruptEn = 1'b0;
    base = execCount;
    applyStimulus();
    checkOutput("rerun_fail_clr", fail, 1'b0);
    checkOutput("rerun_fail_addr_clr", fail_addr, 16'h0000);
    checkOutput("rerun_exec", i2c_exec, 1'b1);
    waitIdle("rerun", 1000);
    checkOutput("rerun_pass", pass, 1'b1);
    checkOutput("rerun_exec_count", execCount - base, 8);

    // Write NACK at 0011: DONE, and nothing further issued.
    nackEn = 1'b1;
    nackAddr = 16'h0011;
    base = execCount;
    applyStimulus();
    waitIdle("nack", 1000);
    checkOutput("nack_fail", fail, 1'b1);
    checkOutput("nack_pass", pass, 1'b0);
    checkOutput("nack_fail_addr", fail_addr, 16'h0011);
    checkOutput("nack_exec_count", execCount - base, 2);
    repeat (30) @(negedge clk);
    #1;
    checkOutput("nack_no_more_exec", execCount - base, 2);
    checkOutput("nack_still_fail", fail, 1'b1);
    nackEn = 1'b0;

    // Start pulses during WR_GAP and RD_WAIT are ignored.
    base = execCount;
    applyStimulus();
    waitExecs("busy_wr", base, 2, 200);
    repeat (5) @(negedge clk);
    applyStimulus();
    waitExecs("busy_rd", base, 6, 300);
    applyStimulus();
    waitIdle("busy", 1000);
    checkOutput("busy_pass", pass, 1'b1);
    checkOutput("busy_exec_count", execCount - base, 8);
    checkTxns("busy", base);

    // Reset during RD_WAIT, then a clean rerun from 0010.
    base = execCount;
    applyStimulus();
    waitExecs("rst", base, 5, 300);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = execCount;
    applyStimulus();
    waitIdle("rst_rerun", 1000);
    checkOutput("rst_rerun_pass", pass, 1'b1);
    checkOutput("rst_rerun_exec_count", execCount - base, 8);
    checkTxns("rst_rerun", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
